fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined RISC core. Owns the program counter and drives the IF/ID pipeline register with the instruction word, its PC and PC+1, the flush (NOP-insert) and IR-hold controls. Talks to instruction memory over a single-outstanding req/ack handshake, honours hazard-unit stalls and redirects from branch/jump resolution.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 19 +
 rtl/fetch_stage_reg16.sv | 23 ++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 16-bit RISC core.
// Provides the datapath width, the NOP encoding presented to IF/ID on a flush
// and the fetch FSM state type.
package fetch_stage_pkg;

   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] NOP_INSTR = 16'hF000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request outstanding at pc
      HOLD  = 2'd1,   // fetched word parked in buffer while IF/ID is stalled
      DROP  = 2'd2    // redirected mid-request; discard the in-flight word
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake bundle (single outstanding request).
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word address, stable while imem_req=1
//   imem_ack   : read data valid this cycle (same-cycle ack allowed)
//   imem_rdata : instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage_reg16.sv
// reg16: 16-bit register with active-low write enable and asynchronous
// active-high reset to INIT.
//   clk, reset : clock, async reset
//   we_n       : 0 = load d on the rising edge, 1 = hold
//   d, q       : data in / registered data out
module reg16
   import fetch_stage_pkg::*;
#(
   parameter logic [DATA_W-1:0] INIT = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_n,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      q <= INIT;
      else if (!we_n) q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, runs the single-
// outstanding instruction-memory handshake and drives the IF/ID register.
//   clk, reset        : clock, async active-high reset
//   stall             : hazard unit hold (IR held, PC not advanced)
//   redirect          : taken branch/jump, highest priority
//   redirect_pc       : redirect target
//   imem              : instruction-memory handshake (master side)
//   toIR/toPC/toPCInc : instruction, its PC and PC+1 for IF/ID
//   flush             : 1 = IF/ID loads NOP_INSTR
//   IR_write          : active-low IR enable (0 = load, 1 = hold)
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirect_pc,
   fetch_stage_if.master     imem,
   output logic [DATA_W-1:0] toIR,
   output logic [DATA_W-1:0] toPC,
   output logic [DATA_W-1:0] toPCInc,
   output logic              flush,
   output logic              IR_write
);

   fetch_state_t      state;
   logic [DATA_W-1:0] pc, pc_d;
   logic              pc_we_n;
   logic [DATA_W-1:0] buf_ir, buf_pc, issued_pc, drop_addr;
   logic [DATA_W-1:0] ir_out, pc_out;
   logic              ack;

   assign ack = imem.imem_ack;

   reg16 #(.INIT(RESET_PC)) u_pc (
      .clk   (clk),
      .reset (reset),
      .we_n  (pc_we_n),
      .d     (pc_d),
      .q     (pc)
   );

   // HOLD parks a completed fetch, so no request is outstanding there. In
   // DROP the PC already holds the redirect target, so the in-flight
   // address is replayed from drop_addr to keep imem_addr stable.
   assign imem.imem_req  = !reset && (state != HOLD);
   assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

   always_comb begin
      pc_we_n = 1'b1;
      pc_d    = pc;
      if (redirect) begin
         pc_we_n = 1'b0;
         pc_d    = redirect_pc;
      end else if (state == FETCH && ack && !stall) begin
         pc_we_n = 1'b0;
         pc_d    = pc + 16'd1;
      end else if (state == HOLD && !stall) begin
         pc_we_n = 1'b0;
         pc_d    = buf_pc + 16'd1;
      end
   end

   // IF/ID outputs. Any time the IR is held, the PC fields fall back to
   // issued_pc so they stay consistent with the instruction already in IR.
   always_comb begin
      flush    = 1'b0;
      IR_write = 1'b0;
      ir_out   = NOP_INSTR;
      pc_out   = issued_pc;
      if (reset || redirect) begin
         flush = 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (ack && !stall) begin
                  ir_out = imem.imem_rdata;
                  pc_out = pc;
               end else if (stall) begin
                  IR_write = 1'b1;
               end else begin
                  flush = 1'b1;
               end
            end
            HOLD: begin
               ir_out = buf_ir;
               if (stall) IR_write = 1'b1;
               else       pc_out   = buf_pc;
            end
            DROP:    flush = 1'b1;
            default: flush = 1'b1;
         endcase
      end
   end

   assign toIR    = ir_out;
   assign toPC    = pc_out;
   assign toPCInc = pc_out + 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         issued_pc <= RESET_PC;
      end else if (redirect) begin
         case (state)
            FETCH:   state <= ack ? FETCH : DROP;
            HOLD:    state <= FETCH;
            DROP:    state <= ack ? FETCH : DROP;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (ack && !stall)     issued_pc <= pc;
               else if (ack && stall) state     <= HOLD;
            end
            HOLD: begin
               if (!stall) begin
                  issued_pc <= buf_pc;
                  state     <= FETCH;
               end
            end
            DROP:    if (ack) state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   // Data-only registers: meaningful only in the state that loaded them.
   always_ff @(posedge clk) begin
      if (state == FETCH && ack && stall && !redirect) begin
         buf_ir <= imem.imem_rdata;
         buf_pc <= pc;
      end
      if (state == FETCH && redirect && !ack) drop_addr <= pc;
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] toIR, toPC, toPCInc;
   logic        flush, IR_write;

   int checks = 0;
   int failures = 0;
   int lat = 0;
   int wcnt = 0;

   fetch_stage_if mem_if ();

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (mem_if.master),
      .toIR        (toIR),
      .toPC        (toPC),
      .toPCInc     (toPCInc),
      .flush       (flush),
      .IR_write    (IR_write)
   );

   always #5 clk = ~clk;

   // Memory: word at address A is 16'h1000+A; ack after lat waiting cycles.
   assign mem_if.imem_ack   = mem_if.imem_req && (wcnt == lat);
   assign mem_if.imem_rdata = 16'h1000 + mem_if.imem_addr;

   always @(posedge clk) begin
      if (!mem_if.imem_req || mem_if.imem_ack) wcnt <= 0;
      else                                     wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held across an edge
      cyc();
      chk("rst_req", mem_if.imem_req, 16'd0);
      chk("rst_flush", flush, 16'd1);
      chk("rst_irw", IR_write, 16'd0);
      chk("rst_ir", toIR, 16'hF000);
      chk("rst_pc", toPC, 16'h0000);
      chk("rst_pcinc", toPCInc, 16'h0001);
      cyc();
      reset = 1'b0;
      #1;
      // zero-wait streaming
      chk("zw0_ir", toIR, 16'h1000);
      chk("zw0_pc", toPC, 16'h0000);
      chk("zw0_flush", flush, 16'd0);
      chk("zw0_addr", mem_if.imem_addr, 16'h0000);
      cyc();
      chk("zw1_ir", toIR, 16'h1001);
      chk("zw1_pc", toPC, 16'h0001);
      cyc();
      chk("zw2_ir", toIR, 16'h1002);
      chk("zw2_pc", toPC, 16'h0002);
      chk("zw2_flush", flush, 16'd0);
      // ack latency 2 on address 3
      cyc();
      lat = 2;
      #1;
      chk("l2a_flush", flush, 16'd1);
      chk("l2a_irw", IR_write, 16'd0);
      chk("l2a_addr", mem_if.imem_addr, 16'h0003);
      chk("l2a_req", mem_if.imem_req, 16'd1);
      cyc();
      chk("l2b_flush", flush, 16'd1);
      chk("l2b_addr", mem_if.imem_addr, 16'h0003);
      cyc();
      chk("l2c_flush", flush, 16'd0);
      chk("l2c_ir", toIR, 16'h1003);
      chk("l2c_pc", toPC, 16'h0003);
      cyc();
      lat = 0;
      #1;
      chk("pc4_ir", toIR, 16'h1004);
      chk("pc4_pc", toPC, 16'h0004);
      // stall for 3 cycles while ack returns at pc=5
      cyc();
      stall = 1'b1;
      #1;
      chk("st1_irw", IR_write, 16'd1);
      chk("st1_flush", flush, 16'd0);
      chk("st1_pc", toPC, 16'h0004);
      chk("st1_pcinc", toPCInc, 16'h0005);
      cyc();
      chk("st2_irw", IR_write, 16'd1);
      chk("st2_pc", toPC, 16'h0004);
      chk("st2_req", mem_if.imem_req, 16'd0);
      cyc();
      chk("st3_irw", IR_write, 16'd1);
      chk("st3_pc", toPC, 16'h0004);
      cyc();
      stall = 1'b0;
      #1;
      chk("rel_irw", IR_write, 16'd0);
      chk("rel_flush", flush, 16'd0);
      chk("rel_ir", toIR, 16'h1005);
      chk("rel_pc", toPC, 16'h0005);
      chk("rel_pcinc", toPCInc, 16'h0006);
      cyc();
      chk("pc6_addr", mem_if.imem_addr, 16'h0006);
      chk("pc6_ir", toIR, 16'h1006);
      // redirect to 0x0040 while request to 7 is pending
      cyc();
      lat = 15;
      redirect = 1'b1;
      redirect_pc = 16'h0040;
      #1;
      chk("rd_flush", flush, 16'd1);
      chk("rd_irw", IR_write, 16'd0);
      chk("rd_addr", mem_if.imem_addr, 16'h0007);
      cyc();
      redirect = 1'b0;
      #1;
      chk("drop_req", mem_if.imem_req, 16'd1);
      chk("drop_addr", mem_if.imem_addr, 16'h0007);
      chk("drop_flush", flush, 16'd1);
      lat = 1;
      #1;
      chk("dropack_flush", flush, 16'd1);
      chk("dropack_ir", toIR, 16'hF000);
      cyc();
      lat = 0;
      #1;
      chk("tgt_addr", mem_if.imem_addr, 16'h0040);
      chk("tgt_ir", toIR, 16'h1040);
      chk("tgt_pc", toPC, 16'h0040);
      chk("tgt_flush", flush, 16'd0);
      // redirect and stall together, target 0xFFFF
      cyc();
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 16'hFFFF;
      #1;
      chk("rs_flush", flush, 16'd1);
      chk("rs_irw", IR_write, 16'd0);
      cyc();
      stall = 1'b0;
      redirect = 1'b0;
      #1;
      chk("ff_addr", mem_if.imem_addr, 16'hFFFF);
      chk("ff_ir", toIR, 16'h0FFF);
      chk("ff_pc", toPC, 16'hFFFF);
      chk("ff_pcinc", toPCInc, 16'h0000);
      cyc();
      chk("wrap_addr", mem_if.imem_addr, 16'h0000);
      chk("wrap_ir", toIR, 16'h1000);
      // reset asserted mid-DROP
      cyc();
      lat = 15;
      redirect = 1'b1;
      redirect_pc = 16'h0020;
      cyc();
      redirect = 1'b0;
      #1;
      chk("md_addr", mem_if.imem_addr, 16'h0001);
      chk("md_flush", flush, 16'd1);
      reset = 1'b1;
      #1;
      chk("mdr_req", mem_if.imem_req, 16'd0);
      chk("mdr_flush", flush, 16'd1);
      chk("mdr_ir", toIR, 16'hF000);
      chk("mdr_pc", toPC, 16'h0000);
      cyc();
      reset = 1'b0;
      lat = 0;
      #1;
      chk("post_addr", mem_if.imem_addr, 16'h0000);
      chk("post_req", mem_if.imem_req, 16'd1);
      chk("post_ir", toIR, 16'h1000);
      chk("post_pc", toPC, 16'h0000);
      chk("post_flush", flush, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
